// File: rtl/game_timer_ctrl.sv
// Two-digit BCD countdown timer with start/pause/expire control, bonus time and a low-time warning.
// Optional blinking of the display under low time is enabled by defining GAME_TIMER_BLINK_EN.
module game_timer_ctrl #(
  parameter int START_SECONDS = 60,
  parameter int BONUS_SECONDS = 5,
  parameter int WARN_SECONDS  = 10
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Bonus,
  output logic [3:0] OnesValue,
  output logic [3:0] TensValue,
  output logic       Running,
  output logic       Expired,
  output logic       TimeUp,
  output logic       Warning,
  output logic       Blank
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUNNING = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [6:0] START_R    = 7'(START_SECONDS);
  localparam logic [7:0] BONUS_R    = 8'(BONUS_SECONDS);
  localparam logic [6:0] WARN_R     = 7'(WARN_SECONDS);
  localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
  localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);

  logic [1:0] r_state;
  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic       r_armed;
  logic       r_running;
  logic       r_expired;
  logic       r_timeUp;
  logic       r_warning;

  logic [1:0] w_nextState;
  logic [6:0] w_curR;
  logic [6:0] w_adjR;
  logic [6:0] w_nextR;
  logic [7:0] w_sum;
  logic       w_tickAcc;
  logic       w_bonusAcc;
  logic       w_nextTimeUp;
  logic       w_nextWarning;

  assign w_curR     = ({3'b000, r_tens} * 7'd10) + {3'b000, r_ones};
  assign w_tickAcc  = (r_state == S_RUNNING) && Tick;
  assign w_bonusAcc = ((r_state == S_RUNNING) || (r_state == S_PAUSED)) && Bonus;

  // Tick and bonus fold into one add/subtract; RUNNING never holds R = 0, so no underflow.
  assign w_sum  = {1'b0, w_curR} + (w_bonusAcc ? BONUS_R : 8'd0) - (w_tickAcc ? 8'd1 : 8'd0);
  assign w_adjR = (w_sum > 8'd99) ? 7'd99 : w_sum[6:0];

  always_comb begin
    w_nextState  = r_state;
    w_nextR      = w_curR;
    w_nextTimeUp = 1'b0;
    case (r_state)
      S_IDLE, S_EXPIRED: begin
        if (Start && r_armed) begin
          w_nextState = S_RUNNING;
          w_nextR     = START_R;
        end
      end
      S_RUNNING: begin
        w_nextR = w_adjR;
        if (w_adjR == 7'd0) begin
          w_nextState  = S_EXPIRED;
          w_nextTimeUp = 1'b1;
        end else if (Pause) begin
          w_nextState = S_PAUSED;
        end
      end
      S_PAUSED: begin
        w_nextR = w_adjR;
        if (Pause) w_nextState = S_RUNNING;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_nextWarning = ((w_nextState == S_RUNNING) || (w_nextState == S_PAUSED)) &&
                         (w_nextR != 7'd0) && (w_nextR <= WARN_R);

  // r_armed swallows a Start that lands on the first edge after Reset releases.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_tens    <= START_TENS;
      r_ones    <= START_ONES;
      r_armed   <= 1'b0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_timeUp  <= 1'b0;
      r_warning <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_tens    <= 4'(w_nextR / 7'd10);
      r_ones    <= 4'(w_nextR % 7'd10);
      r_armed   <= 1'b1;
      r_running <= (w_nextState == S_RUNNING);
      r_expired <= (w_nextState == S_EXPIRED);
      r_timeUp  <= w_nextTimeUp;
      r_warning <= w_nextWarning;
    end
  end

  assign OnesValue = r_ones;
  assign TensValue = r_tens;
  assign Running   = r_running;
  assign Expired   = r_expired;
  assign TimeUp    = r_timeUp;
  assign Warning   = r_warning;

`ifdef GAME_TIMER_BLINK_EN
  logic r_blank;
  logic w_nextBlank;

  // Toggle only on ticks taken while already warning; freezes in PAUSED since no tick is taken there.
  always_comb begin
    w_nextBlank = r_blank;
    if (!w_nextWarning)            w_nextBlank = 1'b0;
    else if (w_tickAcc && r_warning) w_nextBlank = ~r_blank;
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) r_blank <= 1'b0;
    else       r_blank <= w_nextBlank;
  end

  assign Blank = r_blank;
`else
  assign Blank = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: vector table, directed corner sequences and
// randomized pulses against a behavioural model of the countdown rules.
module tb_game_timer_ctrl;

  localparam int START = 60;
  localparam int BONUS = 5;
  localparam int WARN  = 10;
`ifdef GAME_TIMER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       ClockIn = 1'b0;
  logic       Reset   = 1'b1;
  logic       Tick    = 1'b0;
  logic       Start   = 1'b0;
  logic       Pause   = 1'b0;
  logic       Bonus   = 1'b0;
  logic [3:0] OnesValue;
  logic [3:0] TensValue;
  logic       Running;
  logic       Expired;
  logic       TimeUp;
  logic       Warning;
  logic       Blank;

  game_timer_ctrl #(
    .START_SECONDS(START),
    .BONUS_SECONDS(BONUS),
    .WARN_SECONDS(WARN)
  ) dut (
    .ClockIn(ClockIn),
    .Reset(Reset),
    .Tick(Tick),
    .Start(Start),
    .Pause(Pause),
    .Bonus(Bonus),
    .OnesValue(OnesValue),
    .TensValue(TensValue),
    .Running(Running),
    .Expired(Expired),
    .TimeUp(TimeUp),
    .Warning(Warning),
    .Blank(Blank)
  );

  always #10 ClockIn = ~ClockIn;

  int checks = 0;
  int errors = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mstate_t;
  mstate_t mState = M_IDLE;
  int      mR = START;
  bit      mArmed = 1'b0;
  bit      mTimeUp = 1'b0;
  bit      mWarn = 1'b0;
  bit      mBlank = 1'b0;

  typedef struct {
    int t, s, p, b;
    int tens, ones, run, exp, tup, warn;
  } vec_t;
  vec_t vecs[13];

  // Reference model: remaining seconds as a plain integer, rules taken from the state descriptions.
  task automatic modelReset();
    mState = M_IDLE; mR = START; mArmed = 1'b0;
    mTimeUp = 1'b0; mWarn = 1'b0; mBlank = 1'b0;
  endtask

  task automatic modelStep(input int t, input int s, input int p, input int b);
    int nr;
    bit tickTaken;
    bit newWarn;
    tickTaken = 1'b0;
    mTimeUp = 1'b0;
    if (!mArmed) begin
      mArmed = 1'b1;
    end else begin
      case (mState)
        M_IDLE, M_EXP: if (s != 0) begin mState = M_RUN; mR = START; end
        M_RUN: begin
          tickTaken = (t != 0);
          nr = mR - ((t != 0) ? 1 : 0) + ((b != 0) ? BONUS : 0);
          if (nr > 99) nr = 99;
          mR = nr;
          if (nr == 0) begin mState = M_EXP; mTimeUp = 1'b1; end
          else if (p != 0) mState = M_PAUSE;
        end
        M_PAUSE: begin
          if (b != 0) mR = (mR + BONUS > 99) ? 99 : mR + BONUS;
          if (p != 0) mState = M_RUN;
        end
        default: ;
      endcase
    end
    newWarn = (mState == M_RUN || mState == M_PAUSE) && mR > 0 && mR <= WARN;
    if (BLINK) begin
      if (!newWarn) mBlank = 1'b0;
      else if (tickTaken && mWarn) mBlank = ~mBlank;
    end
    mWarn = newWarn;
  endtask

  function automatic logic [15:0] dutOut();
    return {3'b000, TensValue, OnesValue, Running, Expired, TimeUp, Warning, Blank};
  endfunction

  function automatic logic [15:0] modelOut();
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(mR / 10);
    ones = 4'(mR % 10);
    return {3'b000, tens, ones, mState == M_RUN, mState == M_EXP, mTimeUp, mWarn, mBlank};
  endfunction

  task automatic expectEq(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (tens,ones,run,exp,tup,warn,blank)", name, actual, expected);
    end
  endtask

  task automatic expectBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic expectDigits(input string name, input int r);
    logic [7:0] exp8;
    exp8 = {4'(r / 10), 4'(r % 10)};
    checks++;
    if ({TensValue, OnesValue} !== exp8) begin
      errors++;
      $display("[TB] FAIL %s: got %h%h, expected %h", name, TensValue, OnesValue, exp8);
    end
  endtask

  task automatic checkOutput(input string name);
    expectEq(name, dutOut(), modelOut());
  endtask

  // One clock of stimulus; outputs are sampled 1 ns after the edge that consumed it.
  task automatic applyStimulus(input int t, input int s, input int p, input int b);
    Tick = (t != 0); Start = (s != 0); Pause = (p != 0); Bonus = (b != 0);
    @(posedge ClockIn);
    #1;
    Tick = 1'b0; Start = 1'b0; Pause = 1'b0; Bonus = 1'b0;
    modelStep(t, s, p, b);
    checkOutput("model_step");
  endtask

  // Reset lands mid-cycle; a Start on the first edge after release must be ignored.
  task automatic resetDut();
    #3;
    Reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    expectDigits("reset_digits", START);
    expectBit("reset_running", Running, 1'b0);
    @(posedge ClockIn);
    #1;
    Reset = 1'b0;
    applyStimulus(0, 1, 0, 0);
    expectBit("start_at_release_ignored", Running, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0);
  endtask

  initial begin
    vecs[0]  = '{0, 1, 0, 0, 6, 0, 1, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 5, 9, 1, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 5, 8, 1, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 5, 7, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 5, 7, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 5, 7, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 6, 2, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 6, 2, 1, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 6, 2, 1, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 1, 6, 6, 1, 0, 0, 0};
    vecs[10] = '{1, 0, 1, 0, 6, 5, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 6, 5, 1, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 1, 7, 0, 1, 0, 0, 0};

    @(posedge ClockIn);
    #1;
    resetDut();

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].t, vecs[i].s, vecs[i].p, vecs[i].b);
      expectEq($sformatf("vector_%0d", i), dutOut(),
               {3'b000, 4'(vecs[i].tens), 4'(vecs[i].ones), vecs[i].run[0], vecs[i].exp[0],
                vecs[i].tup[0], vecs[i].warn[0], 1'b0});
    end

    // Run down from 11 through the warning band to expiry.
    resetDut();
    applyStimulus(0, 1, 0, 0);
    ticks(49);
    expectDigits("at_11", 11);
    expectBit("no_warn_at_11", Warning, 1'b0);
    applyStimulus(1, 0, 0, 0);
    expectBit("warn_rises_at_10", Warning, 1'b1);
    expectBit("blank_at_10", Blank, 1'b0);
    applyStimulus(1, 0, 0, 0);
    expectBit("blank_at_9", Blank, BLINK);
    applyStimulus(1, 0, 0, 0);
    expectBit("blank_at_8", Blank, 1'b0);
    applyStimulus(1, 0, 0, 0);
    expectBit("blank_at_7", Blank, BLINK);
    ticks(6);
    expectDigits("at_1", 1);
    expectBit("no_timeup_before", TimeUp, 1'b0);
    applyStimulus(1, 0, 0, 0);
    expectDigits("expired_digits", 0);
    expectBit("timeup_pulse", TimeUp, 1'b1);
    expectBit("expired_flag", Expired, 1'b1);
    expectBit("warn_clear_expired", Warning, 1'b0);
    expectBit("blank_clear_expired", Blank, 1'b0);
    applyStimulus(1, 0, 1, 1);
    expectDigits("hold_00", 0);
    expectBit("timeup_one_cycle", TimeUp, 1'b0);
    expectBit("still_expired", Expired, 1'b1);

    // Saturation at 99, then combined tick+bonus at R = 1.
    resetDut();
    applyStimulus(0, 1, 0, 0);
    ticks(3);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1);
    expectDigits("at_97", 97);
    applyStimulus(0, 0, 0, 1);
    expectDigits("saturate_99", 99);
    ticks(98);
    expectDigits("at_01", 1);
    applyStimulus(1, 0, 0, 1);
    expectDigits("tick_bonus_05", 5);
    expectBit("tick_bonus_no_timeup", TimeUp, 1'b0);
    expectBit("tick_bonus_running", Running, 1'b1);

    // Pause holds R against ticks; resume continues counting.
    resetDut();
    applyStimulus(0, 1, 0, 0);
    ticks(30);
    applyStimulus(0, 0, 1, 0);
    ticks(5);
    expectDigits("paused_hold_30", 30);
    applyStimulus(0, 0, 1, 0);
    expectBit("resumed", Running, 1'b1);
    applyStimulus(1, 0, 0, 0);
    expectDigits("resumed_29", 29);

    // Mid-countdown reset at 40, then a normal restart.
    resetDut();
    applyStimulus(0, 1, 0, 0);
    ticks(20);
    expectDigits("at_40", 40);
    resetDut();
    applyStimulus(0, 1, 0, 0);
    expectBit("restart_running", Running, 1'b1);
    applyStimulus(1, 0, 0, 0);
    expectDigits("restart_59", 59);

    // Randomized pulses against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        resetDut();
      end else begin
        applyStimulus(($urandom_range(0, 3) == 0) ? 1 : 0,
                      ($urandom_range(0, 59) == 0) ? 1 : 0,
                      ($urandom_range(0, 15) == 0) ? 1 : 0,
                      ($urandom_range(0, 9) == 0) ? 1 : 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
